// File: rtl/cnt_attr_peak_multi.sv
// cnt_attr_peak_multi: multi-channel peak-hold / decay counter
// Each channel captures a larger sample, holds it HOLD enabled cycles, then
// decays by DECAY per enabled cycle (wrapping or saturating at zero).
// Optional feature macro: CNT_ATTR_PEAK_MAX_EN adds a registered max tracker.
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_cond       per-channel update enable
//   i_clr        per-channel synchronous clear
//   i_sat_mode   1: decay saturates at 0, 0: decay wraps
//   i_inp        packed samples, channel i = i_inp[i*WIDTH +: WIDTH]
//   o_out        packed counter values, same packing as i_inp
//   o_at_zero    per-channel counter == 0
//   o_max_val    [CNT_ATTR_PEAK_MAX_EN] largest channel value, one cycle behind o_out
//   o_max_idx    [CNT_ATTR_PEAK_MAX_EN] lowest channel index holding o_max_val
module cnt_attr_peak_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DECAY    = 1,
    parameter int HOLD     = 0,
    localparam int IW      = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS-1:0]       i_cond,
    input  logic [CHANNELS-1:0]       i_clr,
    input  logic                      i_sat_mode,
    input  logic [CHANNELS*WIDTH-1:0] i_inp,
    output logic [CHANNELS*WIDTH-1:0] o_out,
    output logic [CHANNELS-1:0]       o_at_zero
`ifdef CNT_ATTR_PEAK_MAX_EN
   ,output logic [WIDTH-1:0]          o_max_val,
    output logic [IW-1:0]             o_max_idx
`endif
);
    // A one-bit timer is kept when HOLD is 0; it is loaded with 0 and never counts.
    localparam int HW = HOLD > 0 ? $clog2(HOLD + 1) : 1;
    localparam logic [WIDTH-1:0] DEC = WIDTH'(DECAY);
    localparam logic [HW-1:0]    HLD = HW'(HOLD);
    logic [WIDTH-1:0] r_x    [CHANNELS];
    logic [HW-1:0]    r_hold [CHANNELS];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_x[i]    <= '0;
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (i_clr[i]) begin
                    r_x[i]    <= '0;
                    r_hold[i] <= '0;
                end else if (i_cond[i]) begin
                    if (i_inp[i*WIDTH +: WIDTH] > r_x[i]) begin
                        r_x[i]    <= i_inp[i*WIDTH +: WIDTH];
                        r_hold[i] <= HLD;
                    end else if (r_hold[i] != '0) begin
                        r_hold[i] <= r_hold[i] - 1'b1;
                    end else begin
                        r_x[i] <= (i_sat_mode && r_x[i] < DEC) ? '0 : r_x[i] - DEC;
                    end
                end
            end
        end
    end
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            o_out[i*WIDTH +: WIDTH] = r_x[i];
            o_at_zero[i]            = r_x[i] == '0;
        end
    end
`ifdef CNT_ATTR_PEAK_MAX_EN
    logic [WIDTH-1:0] w_max_val;
    logic [IW-1:0]    w_max_idx;
    logic [WIDTH-1:0] r_max_val;
    logic [IW-1:0]    r_max_idx;
    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_max_val = r_x[0];
        w_max_idx = '0;
        for (int i = 1; i < CHANNELS; i++) begin
            if (r_x[i] > w_max_val) begin
                w_max_val = r_x[i];
                w_max_idx = IW'(i);
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else begin
            r_max_val <= w_max_val;
            r_max_idx <= w_max_idx;
        end
    end
    assign o_max_val = r_max_val;
    assign o_max_idx = r_max_idx;
`endif
endmodule

// File: tb/tb_cnt_attr_peak_multi.sv
// tb_cnt_attr_peak_multi: table, directed and random checks of cnt_attr_peak_multi
module tb_cnt_attr_peak_multi;
    localparam int W = 16;
    localparam int C = 4;
    localparam int D = 1;
    localparam int H = 2;
    localparam int M = 1 << W;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [C-1:0] cond = '0;
    logic [C-1:0] clr = '0;
    logic sat = 1'b0;
    logic [C*W-1:0] inp = '0;
    logic [C*W-1:0] out;
    logic [C-1:0] at_zero;
`ifdef CNT_ATTR_PEAK_MAX_EN
    logic [W-1:0] max_val;
    logic [1:0] max_idx;
`endif
    cnt_attr_peak_multi #(.WIDTH(W), .CHANNELS(C), .DECAY(D), .HOLD(H)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_cond(cond),
        .i_clr(clr),
        .i_sat_mode(sat),
        .i_inp(inp),
        .o_out(out),
        .o_at_zero(at_zero)
`ifdef CNT_ATTR_PEAK_MAX_EN
       ,.o_max_val(max_val),
        .o_max_idx(max_idx)
`endif
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    int m_x[C];
    int m_h[C];
    int m_mv;
    int m_mi;
    typedef struct {
        logic [C-1:0]   cond;
        logic [C-1:0]   clr;
        logic           sat;
        logic [C*W-1:0] inp;
        logic [C*W-1:0] exp;
    } vec_t;
    vec_t tbl[13];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < C; i++) begin
            m_x[i] = 0;
            m_h[i] = 0;
        end
        m_mv = 0;
        m_mi = 0;
    endtask
    // Model: apply the per-channel priority rules to the current inputs, then advance one edge.
    task automatic tick();
        int nx[C];
        int nh[C];
        int v;
        int bv;
        int bi;
        bv = m_x[0];
        bi = 0;
        for (int i = 1; i < C; i++) if (m_x[i] > bv) begin bv = m_x[i]; bi = i; end
        for (int i = 0; i < C; i++) begin
            v = int'(inp[i*W +: W]);
            nx[i] = m_x[i];
            nh[i] = m_h[i];
            if (clr[i]) begin
                nx[i] = 0;
                nh[i] = 0;
            end else if (cond[i]) begin
                if (v > m_x[i]) begin
                    nx[i] = v;
                    nh[i] = H;
                end else if (m_h[i] > 0) nh[i] = m_h[i] - 1;
                else if (sat && m_x[i] < D) nx[i] = 0;
                else nx[i] = (m_x[i] + M - D) % M;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < C; i++) begin
            m_x[i] = nx[i];
            m_h[i] = nh[i];
        end
        m_mv = bv;
        m_mi = bi;
    endtask
    task automatic check_model(input string tag);
        logic [C-1:0] z;
        for (int i = 0; i < C; i++) begin
            z[i] = m_x[i] == 0;
            chk($sformatf("%s out%0d", tag, i), 64'(out[i*W +: W]), 64'(m_x[i]));
        end
        chk($sformatf("%s at_zero", tag), 64'(at_zero), 64'(z));
`ifdef CNT_ATTR_PEAK_MAX_EN
        chk($sformatf("%s max_val", tag), 64'(max_val), 64'(m_mv));
        chk($sformatf("%s max_idx", tag), 64'(max_idx), 64'(m_mi));
`endif
    endtask
    initial begin
        tbl[0]  = '{4'b0001, 4'b0000, 1'b0, {16'd0,   16'd0, 16'd0, 16'd100}, {16'd0,   16'd0, 16'd0,      16'd100}};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b0, {16'd0,   16'd0, 16'd0, 16'd0},   {16'd0,   16'd0, 16'd0,      16'd100}};
        tbl[2]  = '{4'b0001, 4'b0000, 1'b0, {16'd0,   16'd0, 16'd0, 16'd0},   {16'd0,   16'd0, 16'd0,      16'd100}};
        tbl[3]  = '{4'b0001, 4'b0000, 1'b0, {16'd0,   16'd0, 16'd0, 16'd0},   {16'd0,   16'd0, 16'd0,      16'd99}};
        tbl[4]  = '{4'b0001, 4'b0000, 1'b0, {16'd0,   16'd0, 16'd0, 16'd0},   {16'd0,   16'd0, 16'd0,      16'd98}};
        tbl[5]  = '{4'b0010, 4'b0000, 1'b0, {16'd0,   16'd0, 16'd0, 16'd0},   {16'd0,   16'd0, 16'hFFFF,   16'd98}};
        tbl[6]  = '{4'b0000, 4'b0010, 1'b0, {16'd0,   16'd0, 16'd0, 16'd0},   {16'd0,   16'd0, 16'd0,      16'd98}};
        tbl[7]  = '{4'b0010, 4'b0000, 1'b1, {16'd0,   16'd0, 16'd0, 16'd0},   {16'd0,   16'd0, 16'd0,      16'd98}};
        tbl[8]  = '{4'b1000, 4'b1000, 1'b0, {16'd500, 16'd0, 16'd0, 16'd0},   {16'd0,   16'd0, 16'd0,      16'd98}};
        tbl[9]  = '{4'b1000, 4'b0000, 1'b0, {16'd500, 16'd0, 16'd0, 16'd0},   {16'd500, 16'd0, 16'd0,      16'd98}};
        tbl[10] = '{4'b1000, 4'b0000, 1'b0, {16'd500, 16'd0, 16'd0, 16'd0},   {16'd500, 16'd0, 16'd0,      16'd98}};
        tbl[11] = '{4'b1000, 4'b0000, 1'b0, {16'd500, 16'd0, 16'd0, 16'd0},   {16'd500, 16'd0, 16'd0,      16'd98}};
        tbl[12] = '{4'b1000, 4'b0000, 1'b0, {16'd500, 16'd0, 16'd0, 16'd0},   {16'd499, 16'd0, 16'd0,      16'd98}};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", 64'(out), 64'd0);
        chk("reset at_zero", 64'(at_zero), 64'hF);
        rst_n = 1'b1;
        tick();
        chk("post-reset out", 64'(out), 64'd0);
        chk("post-reset at_zero", 64'(at_zero), 64'hF);
        check_model("post-reset");
        for (int r = 0; r < 13; r++) begin
            cond = tbl[r].cond;
            clr  = tbl[r].clr;
            sat  = tbl[r].sat;
            inp  = tbl[r].inp;
            tick();
            chk($sformatf("tbl%0d out", r), 64'(out), 64'(tbl[r].exp));
            check_model($sformatf("tbl%0d", r));
        end
        clr = '0;
        sat = 1'b0;
        cond = 4'b0100;
        inp = {16'd0, 16'd50, 16'd0, 16'd0};
        tick();
        chk("frz peak", 64'(out[2*W +: W]), 64'd50);
        cond = '0;
        inp = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("frz hold%0d", k), 64'(out[2*W +: W]), 64'd50);
        end
        cond = 4'b0100;
        tick();
        chk("frz resume0", 64'(out[2*W +: W]), 64'd50);
        tick();
        chk("frz resume1", 64'(out[2*W +: W]), 64'd50);
        tick();
        chk("frz resume2", 64'(out[2*W +: W]), 64'd49);
        check_model("frz");
        cond = 4'b0001;
        tick();
        chk("pre-rst ch0", 64'(out[W-1:0]), 64'd97);
        cond = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out", 64'(out), 64'd0);
        chk("async rst at_zero", 64'(at_zero), 64'hF);
        #1 rst_n = 1'b1;
        model_reset();
        tick();
        check_model("after async rst");
`ifdef CNT_ATTR_PEAK_MAX_EN
        cond = 4'b0110;
        inp = {16'd0, 16'd300, 16'd300, 16'd0};
        tick();
        cond = '0;
        inp = '0;
        tick();
        chk("max tie val", 64'(max_val), 64'd300);
        chk("max tie idx", 64'(max_idx), 64'd1);
        check_model("max");
`endif
        for (int n = 0; n < 400; n++) begin
            cond = C'($urandom);
            for (int i = 0; i < C; i++) begin
                clr[i] = $urandom_range(0, 9) == 0;
                inp[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 4));
            end
            sat = 1'($urandom);
            tick();
            check_model($sformatf("rnd%0d", n));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
